// File: rtl/cmp_seq_if.sv
// Bus bundle for cmp_seq_ctrl: the start/operand request and the status/result flags.
// The master drives the request. The slave is the comparator sequencer.
interface cmp_seq_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         eq;
    logic         lt;
    logic         gt;

    modport master (output start, a, b, input busy, done, eq, lt, gt);
    modport slave  (input start, a, b, output busy, done, eq, lt, gt);
endinterface

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: serial unsigned magnitude comparator, 2 bits per cycle, MSB slice first.
// Optional macro CMP_SEQ_EARLY_EXIT_EN: finish as soon as the first unequal slice is seen.
// Without it the run always takes W/2 cycles, whatever the data.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | comparing one latched 2-bit slice per cycle
// DONE  | one-cycle result pulse; start here is accepted immediately

module cmp_seq_cmp2 (
    input  logic [1:0] i_x,
    input  logic [1:0] i_y,
    output logic       o_eq,
    output logic       o_lt,
    output logic       o_gt
);
    assign o_eq = (i_x == i_y);
    assign o_lt = (i_x <  i_y);
    assign o_gt = (i_x >  i_y);
endmodule

module cmp_seq_ctrl #(
    parameter int W = 8
) (
    input  logic      clk,
    input  logic      rst,
    cmp_seq_if.slave  bus
);
    localparam int NS = W / 2;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_a, r_b;
    logic [IW-1:0] r_idx;
    logic         r_lt, r_gt;
    logic         r_busy, r_done, r_eq, r_flag_lt, r_flag_gt;
    logic         w_busy_nxt, w_done_nxt, w_eq_nxt, w_lt_nxt, w_gt_nxt;
    logic         w_s_eq, w_s_lt, w_s_gt;
    logic         w_accept, w_last, w_decided;

    // The operands shift left each RUN cycle, so the current slice always sits at the top two bits.
    cmp_seq_cmp2 u_cmp2 (
        .i_x  (r_a[W-1 -: 2]),
        .i_y  (r_b[W-1 -: 2]),
        .o_eq (w_s_eq),
        .o_lt (w_s_lt),
        .o_gt (w_s_gt)
    );

    assign w_accept  = bus.start && (r_state != RUN);
    assign w_decided = r_lt || r_gt;
`ifdef CMP_SEQ_EARLY_EXIT_EN
    assign w_last    = (r_idx == '0) || !w_s_eq;
`else
    assign w_last    = (r_idx == '0);
`endif

    // State register, operand and slice datapath, and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_lt      <= 1'b0;
            r_gt      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_eq      <= 1'b0;
            r_flag_lt <= 1'b0;
            r_flag_gt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_eq      <= w_eq_nxt;
            r_flag_lt <= w_lt_nxt;
            r_flag_gt <= w_gt_nxt;
            if (w_accept) begin
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_idx <= IW'(NS - 1);
                r_lt  <= 1'b0;
                r_gt  <= 1'b0;
            end else if (r_state == RUN) begin
                r_a   <= r_a << 2;
                r_b   <= r_b << 2;
                r_idx <= r_idx - IW'(1);
                if (!w_decided) begin
                    r_lt <= w_s_lt;
                    r_gt <= w_s_gt;
                end
            end
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = bus.start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next output values. The flags change only on entry to DONE and hold otherwise.
    always_comb begin
        w_busy_nxt = (w_state_nxt == RUN);
        w_done_nxt = (w_state_nxt == DONE);
        w_eq_nxt   = r_eq;
        w_lt_nxt   = r_flag_lt;
        w_gt_nxt   = r_flag_gt;
        if ((r_state == RUN) && (w_state_nxt == DONE)) begin
            w_lt_nxt = r_lt || (!w_decided && w_s_lt);
            w_gt_nxt = r_gt || (!w_decided && w_s_gt);
            w_eq_nxt = !w_decided && w_s_eq;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.eq   = r_eq;
    assign bus.lt   = r_flag_lt;
    assign bus.gt   = r_flag_gt;
endmodule

// File: doc/cmp_seq_ctrl.md
CMP_SEQ_CTRL -- requirements
Module: cmp_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits; W even and >= 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to compare a against b.
REQ-005 SHALL have port a, input, W, unsigned operand A.
REQ-006 SHALL have port b, input, W, unsigned operand B.
REQ-007 SHALL have port busy, output, 1, high while a comparison is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-009 SHALL have port eq, output, 1, result flag for a == b.
REQ-010 SHALL have port lt, output, 1, result flag for a < b.
REQ-011 SHALL have port gt, output, 1, result flag for a > b.

Function
REQ-012 SHALL compare operands serially, 2 bits per cycle, MSB slice first, through one internal 2-bit eq/lt/gt comparator instance.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-014 SHALL accept start only when busy=0 (IDLE or DONE); start while busy=1 is ignored and has no effect.
REQ-015 On accepted start: latch a and b, slice index <= W/2-1, clear the internal result, go to RUN; busy=1 from the next cycle.
REQ-016 In RUN, each cycle compares latched slice [2i+1:2i]; the first unequal slice sets the result lt/gt; later slices never change a decided result.
REQ-017 RUN ends after the slice with index 0 (W/2 cycles), then goes to DONE.
REQ-018 In DONE: done=1 and busy=0 for exactly one cycle; eq/lt/gt updated in that same cycle. Next state is RUN if start=1, else IDLE.
REQ-019 Exactly one of eq/lt/gt SHALL be high from the first done pulse onward; flags hold their values until the next done pulse.
REQ-020 Latency: with start sampled at edge k, done is high between edges k+W/2 and k+W/2+1.
REQ-021 Changes to a or b after start has been accepted SHALL NOT affect the comparison in progress.
REQ-022 When start is held continuously, comparisons SHALL run back-to-back, one every W/2+1 cycles.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE and busy=0, done=0, eq=0, lt=0, gt=0, regardless of clk.
REQ-024 Reset during RUN SHALL abort the comparison; no done pulse is produced for it.
REQ-025 The first start accepted after rst deasserts SHALL behave as in REQ-015.

Configuration
REQ-026 Macro CMP_SEQ_EARLY_EXIT_EN SHALL select early termination.
REQ-027 With CMP_SEQ_EARLY_EXIT_EN defined: RUN goes to DONE right after the first unequal slice; latency = j cycles, where j = 1-based position of that slice from the MSB, or W/2 if all slices are equal.
REQ-028 With CMP_SEQ_EARLY_EXIT_EN undefined: latency is always W/2 (REQ-020), independent of the data.

Verification
REQ-029 W=8, a=8'hA5, b=8'hA5, start at edge k -> done at k+4; eq=1, lt=0, gt=0.
REQ-030 W=8, a=8'h40, b=8'h80 -> lt=1; done at k+1 with CMP_SEQ_EARLY_EXIT_EN defined, at k+4 without it.
REQ-031 W=8, a=8'h13, b=8'h12 -> gt=1; done at k+4 in both builds.
REQ-032 Start with a=8'h00, b=8'hFF, then a second start pulse and a change of a to 8'hFF while busy -> the extra start is ignored; lt=1; only one done pulse.
REQ-033 Assert rst at edge k+2 of a RUN -> busy, done and all flags are 0 at once; no done pulse; a following start with a=b=8'h3C gives eq=1.
REQ-034 Hold start=1 with operands swapped between the two requests -> two done pulses W/2+1 cycles apart; the flags track each result.
